adda_spi_responder: RTL and testbench

ADDA_SPI_RESPONDER -- requirements
Module: adda_spi_responder

---
 rtl/adda_spi_responder.sv | 169 ++++++++++++++++
 tb/tb_adda_spi_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adda_spi_responder.sv
// SPI-style 16-bit responder: oversamples SCK/CSLD/SDIN on CLK, receives MSB-first words, shifts out a reply word.
// Optional frame-length checking is enabled by defining ADDA_FRAME_CHECK_EN.
module adda_spi_responder (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SCK,
   input  logic        CSLD,
   input  logic        SDIN,
   output logic        SDOUT,
   input  logic [15:0] TX_DATA,
   input  logic        TX_LOAD,
   output logic [15:0] RX_DATA,
   output logic        RX_VALID,
   output logic        BUSY,
   output logic        FRAME_ERR
);

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2,
      LATCH  = 2'd3
   } state_t;

   state_t      state_r;
   logic        sck_meta_r, sck_sync_r, sck_hist_r;
   logic        csld_meta_r, csld_sync_r, csld_hist_r;
   logic        sdin_meta_r, sdin_sync_r, sdin_hist_r;
   logic [1:0]  wait_cnt_r;
   logic [4:0]  bit_cnt_r;
   logic [15:0] rx_shift_r;
   logic [15:0] reply_r;
   logic [15:0] hold_r;
   logic [15:0] rx_data_r;
   logic        rx_valid_r;
   logic        busy_r;
   logic        sck_fall_s, sck_rise_s, csld_fall_s, csld_rise_s;

   // Two-flop synchronizers plus one history stage per serial input.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sck_meta_r  <= 1'b1;
         sck_sync_r  <= 1'b1;
         sck_hist_r  <= 1'b1;
         csld_meta_r <= 1'b1;
         csld_sync_r <= 1'b1;
         csld_hist_r <= 1'b1;
         sdin_meta_r <= 1'b0;
         sdin_sync_r <= 1'b0;
         sdin_hist_r <= 1'b0;
      end else begin
         sck_meta_r  <= SCK;
         sck_sync_r  <= sck_meta_r;
         sck_hist_r  <= sck_sync_r;
         csld_meta_r <= CSLD;
         csld_sync_r <= csld_meta_r;
         csld_hist_r <= csld_sync_r;
         sdin_meta_r <= SDIN;
         sdin_sync_r <= sdin_meta_r;
         sdin_hist_r <= sdin_sync_r;
      end
   end

   assign sck_fall_s  =  sck_hist_r  & ~sck_sync_r;
   assign sck_rise_s  = ~sck_hist_r  &  sck_sync_r;
   assign csld_fall_s =  csld_hist_r & ~csld_sync_r;
   assign csld_rise_s = ~csld_hist_r &  csld_sync_r;

   // Holding register for the next reply word.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hold_r <= 16'h0000;
      end else if (TX_LOAD) begin
         hold_r <= TX_DATA;
      end
   end

`ifdef ADDA_FRAME_CHECK_EN
   logic frame_err_r;
`endif

   // Frame state machine with registered strobes and shift registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= WAIT;
         wait_cnt_r <= 2'd0;
         bit_cnt_r  <= 5'd0;
         rx_shift_r <= 16'h0000;
         reply_r    <= 16'h0000;
         rx_data_r  <= 16'h0000;
         rx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
`ifdef ADDA_FRAME_CHECK_EN
         frame_err_r <= 1'b0;
`endif
      end else begin
         rx_valid_r <= 1'b0;
`ifdef ADDA_FRAME_CHECK_EN
         frame_err_r <= 1'b0;
`endif
         case (state_r)
            // The reset values of the synchronizer read as "high", so CSLD must stay
            // high until the pipeline has refilled with real pin samples.
            WAIT: begin
               if (!csld_sync_r) begin
                  wait_cnt_r <= 2'd0;
               end else if (wait_cnt_r == 2'd2) begin
                  state_r <= IDLE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 2'd1;
               end
            end
            IDLE: begin
               if (csld_fall_s) begin
                  state_r   <= ACTIVE;
                  busy_r    <= 1'b1;
                  bit_cnt_r <= 5'd0;
                  reply_r   <= TX_LOAD ? TX_DATA : hold_r;
               end
            end
            ACTIVE: begin
               if (csld_rise_s) begin
                  state_r <= LATCH;
                  if (bit_cnt_r != 5'd0) begin
`ifdef ADDA_FRAME_CHECK_EN
                     if (bit_cnt_r == 5'd16) begin
                        rx_data_r  <= rx_shift_r;
                        rx_valid_r <= 1'b1;
                     end else begin
                        frame_err_r <= 1'b1;
                     end
`else
                     rx_data_r  <= rx_shift_r;
                     rx_valid_r <= 1'b1;
`endif
                  end
               end else if (sck_fall_s) begin
                  // The history stage holds SDIN as it was just before the fall.
                  rx_shift_r <= {rx_shift_r[14:0], sdin_hist_r};
                  if (bit_cnt_r != 5'd31) begin
                     bit_cnt_r <= bit_cnt_r + 5'd1;
                  end
               end else if (sck_rise_s) begin
                  reply_r <= {reply_r[14:0], 1'b0};
               end
            end
            LATCH: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= WAIT;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign SDOUT    = reply_r[15];
   assign RX_DATA  = rx_data_r;
   assign RX_VALID = rx_valid_r;
   assign BUSY     = busy_r;
`ifdef ADDA_FRAME_CHECK_EN
   assign FRAME_ERR = frame_err_r;
`else
   assign FRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_adda_spi_responder.sv
// Scoreboard bench for adda_spi_responder: received words are queued when frames are driven
// and checked by a monitor on RX_VALID; reply bits are sampled on every SCK fall.
module tb_adda_spi_responder;

   localparam int HALF = 128;

   logic        CLK = 1'b0;
   logic        RST_N, SCK, CSLD, SDIN, TX_LOAD;
   logic [15:0] TX_DATA;
   logic        SDOUT, RX_VALID, BUSY, FRAME_ERR;
   logic [15:0] RX_DATA;

   int          tests = 0;
   int          fails = 0;
   int          valid_cnt = 0;
   int          err_cnt = 0;
   int          bits_in = 0;
   int          samp_n = 0;
   logic [15:0] model_rx = 16'h0000;
   logic [15:0] reply_seen = 16'h0000;
   logic [15:0] mon_exp;
   logic [15:0] exp_q[$];

   adda_spi_responder dut (
      .CLK(CLK), .RST_N(RST_N), .SCK(SCK), .CSLD(CSLD), .SDIN(SDIN), .SDOUT(SDOUT),
      .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   // Monitor: pop the scoreboard on every RX_VALID strobe.
   always @(negedge CLK) begin
      if (FRAME_ERR === 1'b1) err_cnt++;
      if (RX_VALID === 1'b1) begin
         valid_cnt++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected: got RX_DATA=%h, required no RX_VALID", RX_DATA);
         end else begin
            mon_exp = exp_q.pop_front();
            if (RX_DATA !== mon_exp) begin
               fails++;
               $display("FAIL rx_data: got %h, required %h", RX_DATA, mon_exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit counted);
      SDIN = b;
      tick(HALF);
      if (samp_n < 16) reply_seen = {reply_seen[14:0], SDOUT};
      samp_n++;
      SCK = 1'b0;
      if (counted) begin
         model_rx = {model_rx[14:0], b};
         bits_in++;
      end
      tick(HALF);
      SCK = 1'b1;
   endtask

   task automatic start_frame();
      CSLD = 1'b0;
      bits_in = 0;
      samp_n = 0;
      reply_seen = 16'h0000;
      tick(16);
   endtask

   // CSLD has just been raised; check the strobe timing edge by edge.
   task automatic end_frame(input string nm);
      bit exp_v, exp_e, want;
      exp_v = (bits_in >= 1);
      exp_e = 1'b0;
`ifdef ADDA_FRAME_CHECK_EN
      if (bits_in >= 1 && bits_in != 16) begin
         exp_v = 1'b0;
         exp_e = 1'b1;
      end
`endif
      if (exp_v) exp_q.push_back(model_rx);
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         want = (i == 3) ? exp_v : 1'b0;
         tests++;
         if (RX_VALID !== want) begin
            fails++;
            $display("FAIL %s rx_valid_edge%0d: got %b, required %b", nm, i, RX_VALID, want);
         end
         if (i == 3) begin
            tests++;
            if (FRAME_ERR !== exp_e) begin
               fails++;
               $display("FAIL %s frame_err: got %b, required %b", nm, FRAME_ERR, exp_e);
            end
         end
      end
      tests++;
      if (BUSY !== 1'b0) begin
         fails++;
         $display("FAIL %s busy_after: got %b, required 0", nm, BUSY);
      end
   endtask

   task automatic frame(input logic [31:0] data, input int n, input int load_at,
                        input logic [15:0] load_word, input bit coincident,
                        input bit chk_reply, input logic [15:0] exp_reply, input string nm);
      start_frame();
      for (int i = 0; i < n; i++) begin
         if (i == load_at) begin
            TX_DATA = load_word;
            TX_LOAD = 1'b1;
            tick(1);
            TX_LOAD = 1'b0;
         end
         if (coincident && i == n - 1) begin
            SDIN = data[n-1-i];
            tick(HALF);
            if (samp_n < 16) reply_seen = {reply_seen[14:0], SDOUT};
            samp_n++;
            SCK = 1'b0;
            CSLD = 1'b1;
         end else begin
            send_bit(data[n-1-i], 1'b1);
         end
      end
      if (!coincident) begin
         tick(HALF);
         CSLD = 1'b1;
      end
      end_frame(nm);
      SCK = 1'b1;
      tick(8);
      if (chk_reply) begin
         tests++;
         if (reply_seen !== exp_reply) begin
            fails++;
            $display("FAIL %s reply: got %h, required %h", nm, reply_seen, exp_reply);
         end
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; SCK = 1'b1; CSLD = 1'b1; SDIN = 1'b0; TX_LOAD = 1'b0; TX_DATA = 16'h0000;
      tick(4);
      tests++;
      if ({SDOUT, RX_DATA, RX_VALID, BUSY, FRAME_ERR} !== 20'h00000) begin
         fails++;
         $display("FAIL reset_outputs: got %h, required 00000",
                  {SDOUT, RX_DATA, RX_VALID, BUSY, FRAME_ERR});
      end
      RST_N = 1'b1;
      model_rx = 16'h0000;
      tick(8);
   endtask

   task automatic test_basic();
      int v0;
      v0 = valid_cnt;
      TX_DATA = 16'hA5C3; TX_LOAD = 1'b1;
      tick(1);
      TX_LOAD = 1'b0;
      frame(32'h1234, 16, -1, 16'h0000, 1'b0, 1'b1, 16'hA5C3, "basic");
      tests++;
      if (valid_cnt - v0 !== 1) begin
         fails++;
         $display("FAIL basic_valid_count: got %0d, required 1", valid_cnt - v0);
      end
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_cnt;
      frame(32'hFFFF, 16, 8, 16'h8001, 1'b0, 1'b1, 16'hA5C3, "b2b_first");
      frame(32'h0001, 16, -1, 16'h0000, 1'b0, 1'b1, 16'h8001, "b2b_second");
      tests++;
      if (valid_cnt - v0 !== 2) begin
         fails++;
         $display("FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0);
      end
   endtask

   task automatic test_long_frame();
      int e0;
      e0 = err_cnt;
      frame(32'hABCDE, 20, -1, 16'h0000, 1'b0, 1'b1, 16'h8001, "long");
`ifdef ADDA_FRAME_CHECK_EN
      tests++;
      if (RX_DATA !== 16'h0001 || err_cnt - e0 !== 1) begin
         fails++;
         $display("FAIL long_checked: got RX_DATA=%h errs=%0d, required 0001 and 1", RX_DATA, err_cnt - e0);
      end
`else
      tests++;
      if (RX_DATA !== 16'hBCDE || err_cnt - e0 !== 0) begin
         fails++;
         $display("FAIL long_data: got RX_DATA=%h errs=%0d, required bcde and 0", RX_DATA, err_cnt - e0);
      end
`endif
   endtask

   task automatic test_empty_frame();
      int v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      CSLD = 1'b0;
      tick(16);
      tests++;
      if (BUSY !== 1'b1) begin
         fails++;
         $display("FAIL empty_busy_high: got %b, required 1", BUSY);
      end
      CSLD = 1'b1;
      tick(8);
      tests++;
      if (BUSY !== 1'b0 || valid_cnt != v0 || err_cnt != e0) begin
         fails++;
         $display("FAIL empty_after: got busy=%b valids=%0d errs=%0d, required 0 0 0",
                  BUSY, valid_cnt - v0, err_cnt - e0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      logic [7:0] tail;
      tail = 8'h3C;
      v0 = valid_cnt;
      start_frame();
      for (int i = 0; i < 8; i++) send_bit(tail[7-i], 1'b1);
      RST_N = 1'b0;
      model_rx = 16'h0000;
      tick(2);
      tests++;
      if (BUSY !== 1'b0 || RX_DATA !== 16'h0000) begin
         fails++;
         $display("FAIL midrst_outputs: got busy=%b RX_DATA=%h, required 0 0000", BUSY, RX_DATA);
      end
      RST_N = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(tail[i], 1'b0);
      tick(HALF);
      CSLD = 1'b1;
      tick(12);
      tests++;
      if (valid_cnt != v0 || BUSY !== 1'b0) begin
         fails++;
         $display("FAIL midrst_no_valid: got valids=%0d busy=%b, required 0 0", valid_cnt - v0, BUSY);
      end
      frame(32'h5A5A, 16, -1, 16'h0000, 1'b0, 1'b1, 16'h0000, "after_rst");
      tests++;
      if (RX_DATA !== 16'h5A5A) begin
         fails++;
         $display("FAIL after_rst_data: got %h, required 5a5a", RX_DATA);
      end
   endtask

   task automatic test_coincident();
      frame(32'h1234, 16, -1, 16'h0000, 1'b1, 1'b0, 16'h0000, "coincident");
`ifndef ADDA_FRAME_CHECK_EN
      tests++;
      if (RX_DATA !== 16'h091A) begin
         fails++;
         $display("FAIL coincident_data: got %h, required 091a", RX_DATA);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_long_frame();
      test_empty_frame();
      test_reset_mid_frame();
      test_coincident();
      tick(8);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
